memory_access: RTL
==================

Name: memory_access

Overview:
- Pipeline stage 4 of the RV32I core. Sits directly downstream of execute and upstream of writeback.
- Passes ALU results through unchanged.
- For loads and stores, runs one pipelined-Wishbone transaction on the main_memory data port.
- Handles byte-lane select, store data replication, load sign/zero extension and misalignment detection. Stalls upstream while a bus access is outstanding.

Parameters:
- None. Encodings come from the shared package.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- execute_result  in  32  ALU result; effective address for loads/stores
- execute_rs2_data  in  32  store data
- execute_funct3  in  3  access size/sign
- execute_opcode_type  in  `OPCODE_WIDTH  instruction class
- execute_rd  in  5  destination register
- execute_rd_wr_en  in  1  instruction writes rd
- execute_pc  in  32  instruction PC
- execute_exception  in  `EXCEPTION_WIDTH  upstream exception flags
- clk_en  in  1  execute output valid this cycle
- stall  in  1  downstream (writeback) stall
- flush  in  1  downstream flush request
- memory_rd  out  5  destination register
- memory_rd_wr_en  out  1  write rd
- memory_rd_wr_data  out  32  value to write
- memory_rd_valid  out  1  memory_rd_wr_data final (forwarding qualifier)
- memory_pc  out  32  instruction PC
- memory_exception  out  `EXCEPTION_WIDTH  accumulated exception flags
- next_clk_en  out  1  output valid to writeback
- next_stall  out  1  stall request to execute
- next_flush  out  1  flush to execute
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_wr_en  out  1  1 = store
- wb_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- wb_wr_data  out  32  lane-replicated store data
- wb_wr_sel  out  4  byte enables
- wb_ack  in  1  transaction complete
- wb_stall  in  1  slave not accepting strobe
- wb_rd_data  in  32  load data

Behaviour:
- Reset (async): every output is 0; state goes to IDLE. wb_cyc/wb_stb drop immediately, including mid-transaction.
- "Accept" means clk_en && !stall && !flush in IDLE.

Non-memory op:
- Registered pass-through, latency 1 cycle.
- next_clk_en=1, memory_rd_valid=execute_rd_wr_en.

Load/store, aligned:
- On accept, latch address, data, funct3 and rd, then go to REQ.
- next_clk_en=0 and memory_rd_valid=0 until completion.

FSM states:
- IDLE: waits for accept.
- REQ: wb_cyc=wb_stb=1.
  - !wb_stall: go to WAIT and drop stb.
  - wb_ack in the same cycle as acceptance: complete directly.
- WAIT: wb_cyc=1, wb_stb=0. On wb_ack, complete.
- Completion: register memory_rd_wr_data. Pulse next_clk_en for 1 cycle (unless squashed), set memory_rd_valid=1 for loads, return to IDLE.
  - Load-use latency: 2 cycles minimum after accept.

Stalls and flushes:
- next_stall = stall || state!=IDLE.
- While stall=1, output registers hold their values.
- next_flush = flush, combinational.
- Flush during REQ/WAIT: the bus transaction still runs to wb_ack (stores cannot be aborted). The result is squashed: next_clk_en stays 0 and memory_rd_wr_en=0.

Store encoding:
- SB: wr_sel = 4'b0001<<addr[1:0], wr_data = {4{rs2[7:0]}}.
- SH: wr_sel = addr[1] ? 4'b1100 : 4'b0011, wr_data = {2{rs2[15:0]}}.
- SW: wr_sel = 4'b1111, wr_data = rs2.
- Stores: memory_rd_wr_en=0.

Load encoding:
- Select byte/half by addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Loads: wb_wr_sel=4'b1111, wb_wr_en=0.

Misalignment:
- Condition: half with addr[0]=1, or word with addr[1:0]!=0.
- No bus cycle is started; latency 1 like pass-through.
- Set LOAD_MISALIGNED or STORE_MISALIGNED in memory_exception (OR with execute_exception).
- memory_rd_wr_en=0.

Other rules:
- Incoming execute_exception!=0 suppresses the bus access and passes through.
- Undefined funct3 for a memory op is treated as misaligned (exception, no access).
- wb_ack outside REQ/WAIT is ignored.

Decomposition:
- Package rv32i_pkg holds:
  - OPCODE_LOAD/OPCODE_STORE encodings
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - exception bit indices LOAD_MISALIGNED and STORE_MISALIGNED
  - the FSM state enum
- One sub-module, load_store_align: combinational wr_sel/wr_data generation, load extraction/extension and misalignment flag. Shared with future cache work.

Test Plan:
- ADD result 0x00000055, rd=5 -> 1 cycle later memory_rd_wr_data=0x55, memory_rd=5, next_clk_en pulse, no wb_cyc.
- LW addr 0x10, mem[0x10]=0xDEADBEEF, 1-cycle ack -> wb_addr=0x10, wr_sel=4'b1111, memory_rd_wr_data=0xDEADBEEF, next_stall high during REQ/WAIT.
- LB addr 0x13 -> 0xFFFFFFDE; LBU addr 0x13 -> 0x000000DE; LHU addr 0x12 -> 0x0000DEAD.
- SH addr 0x12, rs2=0x1234ABCD, wb_stall held 3 cycles -> wb_stb held 4 cycles, wr_sel=4'b1100, wr_data=0xABCDABCD, wb_wr_en=1, memory_rd_wr_en=0.
- LW addr 0x11 -> no wb_cyc, LOAD_MISALIGNED set, next_clk_en after 1 cycle.
- Flush asserted in WAIT on a SW -> ack still consumed, next_clk_en never pulses; rst asserted in REQ -> wb_cyc=0 in the same cycle, state IDLE.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the memory stage: opcode classes, funct3
// access sizes, exception bit positions and the bus FSM states.
package rv32i_pkg;

  localparam int unsigned OPCODE_WIDTH    = 3;
  localparam int unsigned EXCEPTION_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_ALU   = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD  = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_STORE = 3'd2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam int unsigned LOAD_MISALIGNED  = 0;
  localparam int unsigned STORE_MISALIGNED = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/memory_access_if.sv
// Pipelined Wishbone data port between the memory stage and main memory.
interface memory_access_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_wr_en;
  logic [31:0] wb_addr;
  logic [31:0] wb_wr_data;
  logic [3:0]  wb_wr_sel;
  logic        wb_ack;
  logic        wb_stall;
  logic [31:0] wb_rd_data;

  modport master (
    output wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel,
    input  wb_ack, wb_stall, wb_rd_data
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel,
    output wb_ack, wb_stall, wb_rd_data
  );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for loads/stores: store lane select and replication,
// load extraction with sign/zero extension, and misalignment detection.
module load_store_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  wr_sel_c,
  output logic [31:0] wr_data_c,
  output logic [31:0] load_data_c,
  output logic        misaligned_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = load_raw[7:0];
      2'd1:    byte_sel = load_raw[15:8];
      2'd2:    byte_sel = load_raw[23:16];
      default: byte_sel = load_raw[31:24];
    endcase
    half_sel = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
  end

  // Undefined funct3 values are reported as misaligned so no bus cycle starts.
  always_comb begin
    wr_sel_c     = 4'b1111;
    wr_data_c    = store_data;
    load_data_c  = load_raw;
    misaligned_c = 1'b0;
    if (is_store) begin
      case (funct3)
        FUNCT3_SB: begin
          wr_sel_c  = 4'b0001 << addr_lo;
          wr_data_c = {4{store_data[7:0]}};
        end
        FUNCT3_SH: begin
          wr_sel_c     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wr_data_c    = {2{store_data[15:0]}};
          misaligned_c = addr_lo[0];
        end
        FUNCT3_SW: misaligned_c = (addr_lo != 2'b00);
        default:   misaligned_c = 1'b1;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB:  load_data_c = {{24{byte_sel[7]}}, byte_sel};
        FUNCT3_LBU: load_data_c = {24'd0, byte_sel};
        FUNCT3_LH: begin
          load_data_c  = {{16{half_sel[15]}}, half_sel};
          misaligned_c = addr_lo[0];
        end
        FUNCT3_LHU: begin
          load_data_c  = {16'd0, half_sel};
          misaligned_c = addr_lo[0];
        end
        FUNCT3_LW: misaligned_c = (addr_lo != 2'b00);
        default:   misaligned_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/memory_access.sv
// RV32I memory stage: registered ALU pass-through, plus one pipelined
// Wishbone transaction per load/store with upstream stall while it runs.
module memory_access
  import rv32i_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                execute_result,
  input  logic [31:0]                execute_rs2_data,
  input  logic [2:0]                 execute_funct3,
  input  logic [OPCODE_WIDTH-1:0]    execute_opcode_type,
  input  logic [4:0]                 execute_rd,
  input  logic                       execute_rd_wr_en,
  input  logic [31:0]                execute_pc,
  input  logic [EXCEPTION_WIDTH-1:0] execute_exception,
  input  logic                       clk_en,
  input  logic                       stall,
  input  logic                       flush,
  output logic [4:0]                 memory_rd,
  output logic                       memory_rd_wr_en,
  output logic [31:0]                memory_rd_wr_data,
  output logic                       memory_rd_valid,
  output logic [31:0]                memory_pc,
  output logic [EXCEPTION_WIDTH-1:0] memory_exception,
  output logic                       next_clk_en,
  output logic                       next_stall,
  output logic                       next_flush,
  memory_access_if.master            wb
);

  mem_state_e                 state_q, state_d;
  logic [4:0]                 memory_rd_q, memory_rd_d;
  logic                       memory_rd_wr_en_q, memory_rd_wr_en_d;
  logic [31:0]                memory_rd_wr_data_q, memory_rd_wr_data_d;
  logic                       memory_rd_valid_q, memory_rd_valid_d;
  logic [31:0]                memory_pc_q, memory_pc_d;
  logic [EXCEPTION_WIDTH-1:0] memory_exception_q, memory_exception_d;
  logic                       next_clk_en_q, next_clk_en_d;
  logic                       wb_cyc_q, wb_cyc_d;
  logic                       wb_stb_q, wb_stb_d;
  logic                       wb_wr_en_q, wb_wr_en_d;
  logic [31:0]                wb_addr_q, wb_addr_d;
  logic [31:0]                wb_wr_data_q, wb_wr_data_d;
  logic [3:0]                 wb_wr_sel_q, wb_wr_sel_d;
  logic [1:0]                 addr_lo_q, addr_lo_d;
  logic [2:0]                 funct3_q, funct3_d;
  logic                       is_load_q, is_load_d;
  logic                       rd_wr_en_q, rd_wr_en_d;
  logic                       squash_q, squash_d;

  logic        is_load, is_store, is_mem, idle, bus_done, squashed;
  logic [1:0]  align_addr_lo;
  logic [2:0]  align_funct3;
  logic        align_is_store;
  logic [3:0]  align_wr_sel;
  logic [31:0] align_wr_data;
  logic [31:0] align_load_data;
  logic        align_misaligned;

  assign is_load  = (execute_opcode_type == OPCODE_LOAD);
  assign is_store = (execute_opcode_type == OPCODE_STORE);
  assign is_mem   = is_load || is_store;
  assign idle     = (state_q == ST_IDLE);

  // The aligner looks at the incoming op while idle and at the latched op otherwise.
  assign align_addr_lo  = idle ? execute_result[1:0] : addr_lo_q;
  assign align_funct3   = idle ? execute_funct3 : funct3_q;
  assign align_is_store = idle ? is_store : !is_load_q;

  load_store_align u_align (
    .addr_lo      (align_addr_lo),
    .funct3       (align_funct3),
    .is_store     (align_is_store),
    .store_data   (execute_rs2_data),
    .load_raw     (wb.wb_rd_data),
    .wr_sel_c     (align_wr_sel),
    .wr_data_c    (align_wr_data),
    .load_data_c  (align_load_data),
    .misaligned_c (align_misaligned)
  );

  always_comb begin
    state_d             = state_q;
    memory_rd_d         = memory_rd_q;
    memory_rd_wr_en_d   = memory_rd_wr_en_q;
    memory_rd_wr_data_d = memory_rd_wr_data_q;
    memory_rd_valid_d   = memory_rd_valid_q;
    memory_pc_d         = memory_pc_q;
    memory_exception_d  = memory_exception_q;
    next_clk_en_d       = next_clk_en_q;
    wb_cyc_d            = wb_cyc_q;
    wb_stb_d            = wb_stb_q;
    wb_wr_en_d          = wb_wr_en_q;
    wb_addr_d           = wb_addr_q;
    wb_wr_data_d        = wb_wr_data_q;
    wb_wr_sel_d         = wb_wr_sel_q;
    addr_lo_d           = addr_lo_q;
    funct3_d            = funct3_q;
    is_load_d           = is_load_q;
    rd_wr_en_d          = rd_wr_en_q;
    squash_d            = squash_q;
    bus_done            = 1'b0;
    squashed            = squash_q || flush;

    unique case (state_q)
      ST_IDLE: begin
        if (!stall) begin
          if (flush) begin
            next_clk_en_d     = 1'b0;
            memory_rd_wr_en_d = 1'b0;
            memory_rd_valid_d = 1'b0;
          end else if (clk_en) begin
            memory_rd_d        = execute_rd;
            memory_pc_d        = execute_pc;
            memory_exception_d = execute_exception;
            if (is_load && align_misaligned)
              memory_exception_d[LOAD_MISALIGNED] = 1'b1;
            if (is_store && align_misaligned)
              memory_exception_d[STORE_MISALIGNED] = 1'b1;
            if (is_mem && (execute_exception == '0) && !align_misaligned) begin
              state_d           = ST_REQ;
              wb_cyc_d          = 1'b1;
              wb_stb_d          = 1'b1;
              wb_wr_en_d        = is_store;
              wb_addr_d         = {execute_result[31:2], 2'b00};
              wb_wr_data_d      = align_wr_data;
              wb_wr_sel_d       = align_wr_sel;
              addr_lo_d         = execute_result[1:0];
              funct3_d          = execute_funct3;
              is_load_d         = is_load;
              rd_wr_en_d        = execute_rd_wr_en;
              squash_d          = 1'b0;
              next_clk_en_d     = 1'b0;
              memory_rd_wr_en_d = 1'b0;
              memory_rd_valid_d = 1'b0;
            end else begin
              memory_rd_wr_data_d = execute_result;
              next_clk_en_d       = 1'b1;
              memory_rd_wr_en_d   = execute_rd_wr_en && !is_mem;
              memory_rd_valid_d   = execute_rd_wr_en && !is_mem;
            end
          end else begin
            next_clk_en_d = 1'b0;
          end
        end
      end
      ST_REQ: begin
        squash_d = squashed;
        if (wb.wb_ack) begin
          bus_done = 1'b1;
        end else if (!wb.wb_stall) begin
          state_d  = ST_WAIT;
          wb_stb_d = 1'b0;
        end
      end
      ST_WAIT: begin
        squash_d = squashed;
        if (wb.wb_ack) bus_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The stage outputs hold a bubble while the bus runs, so completion may overwrite them.
    if (bus_done) begin
      state_d             = ST_IDLE;
      wb_cyc_d            = 1'b0;
      wb_stb_d            = 1'b0;
      squash_d            = 1'b0;
      memory_rd_wr_data_d = align_load_data;
      next_clk_en_d       = !squashed;
      memory_rd_wr_en_d   = is_load_q && rd_wr_en_q && !squashed;
      memory_rd_valid_d   = is_load_q && !squashed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      memory_rd_q         <= '0;
      memory_rd_wr_en_q   <= 1'b0;
      memory_rd_wr_data_q <= '0;
      memory_rd_valid_q   <= 1'b0;
      memory_pc_q         <= '0;
      memory_exception_q  <= '0;
      next_clk_en_q       <= 1'b0;
      wb_cyc_q            <= 1'b0;
      wb_stb_q            <= 1'b0;
      wb_wr_en_q          <= 1'b0;
      wb_addr_q           <= '0;
      wb_wr_data_q        <= '0;
      wb_wr_sel_q         <= '0;
      addr_lo_q           <= '0;
      funct3_q            <= '0;
      is_load_q           <= 1'b0;
      rd_wr_en_q          <= 1'b0;
      squash_q            <= 1'b0;
    end else begin
      state_q             <= state_d;
      memory_rd_q         <= memory_rd_d;
      memory_rd_wr_en_q   <= memory_rd_wr_en_d;
      memory_rd_wr_data_q <= memory_rd_wr_data_d;
      memory_rd_valid_q   <= memory_rd_valid_d;
      memory_pc_q         <= memory_pc_d;
      memory_exception_q  <= memory_exception_d;
      next_clk_en_q       <= next_clk_en_d;
      wb_cyc_q            <= wb_cyc_d;
      wb_stb_q            <= wb_stb_d;
      wb_wr_en_q          <= wb_wr_en_d;
      wb_addr_q           <= wb_addr_d;
      wb_wr_data_q        <= wb_wr_data_d;
      wb_wr_sel_q         <= wb_wr_sel_d;
      addr_lo_q           <= addr_lo_d;
      funct3_q            <= funct3_d;
      is_load_q           <= is_load_d;
      rd_wr_en_q          <= rd_wr_en_d;
      squash_q            <= squash_d;
    end
  end

  assign memory_rd         = memory_rd_q;
  assign memory_rd_wr_en   = memory_rd_wr_en_q;
  assign memory_rd_wr_data = memory_rd_wr_data_q;
  assign memory_rd_valid   = memory_rd_valid_q;
  assign memory_pc         = memory_pc_q;
  assign memory_exception  = memory_exception_q;
  assign next_clk_en       = next_clk_en_q;
  assign next_stall        = stall || !idle;
  assign next_flush        = flush;
  assign wb.wb_cyc         = wb_cyc_q;
  assign wb.wb_stb         = wb_stb_q;
  assign wb.wb_wr_en       = wb_wr_en_q;
  assign wb.wb_addr        = wb_addr_q;
  assign wb.wb_wr_data     = wb_wr_data_q;
  assign wb.wb_wr_sel      = wb_wr_sel_q;

endmodule
